pipe_skid_stage: RTL



---
 rtl/pipe_skid_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline stage (main + skid register) carrying a data word and its PC.
// Optional stall counter is enabled by defining PIPE_SKID_STALL_COUNT_EN.
module pipe_skid_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
`ifdef PIPE_SKID_STALL_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc
`ifdef PIPE_SKID_STALL_COUNT_EN
  , output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake flags come only from state, keeping in_ready free of any path from out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_pc    = main_pc_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = BUSY;
          main_data_d = in_data;
          main_pc_d   = in_pc;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_pc_d   = in_pc;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_pc_d   = in_pc;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d     = BUSY;
          main_data_d = skid_data_q;
          main_pc_d   = skid_pc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Squash drops every held and incoming beat; payload registers keep their old contents.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = main_data_q;
      main_pc_d   = main_pc_q;
      skid_data_d = skid_data_q;
      skid_pc_d   = skid_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_pc_q   <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

`ifdef PIPE_SKID_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles a beat waits on downstream; flush leaves it untouched.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
